// File: rtl/counter_monitor_if.sv
// Signal bundle between a monitored counter's consumer side and counter_monitor.
// The master drives the samples; the slave (the monitor) returns its status.
interface counter_monitor_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ERR_W = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_clear;
  logic             locked;
  logic             step_err;
  logic             bound_err;
  logic [WIDTH-1:0] expected;
  logic [ERR_W-1:0] err_count;
  logic             first_err_seen;
  logic [WIDTH-1:0] first_err_val;

  modport master (
    output in_valid, in_data, in_clear,
    input  locked, step_err, bound_err, expected, err_count, first_err_seen, first_err_val
  );

  modport slave (
    input  in_valid, in_data, in_clear,
    output locked, step_err, bound_err, expected, err_count, first_err_seen, first_err_val
  );
endinterface

// File: rtl/counter_monitor.sv
// Passive checker for a free-running up-counter: every valid sample must be the previous
// sample plus one (mod 2^WIDTH) and must not exceed BOUND. Violations are reported as
// registered one-cycle pulses, a saturating error count and a first-error capture.
// WIDTH is expected to be below 64.
module counter_monitor #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BOUND = 100,
  parameter int unsigned ERR_W = 8
) (
  input logic              CLK,
  input logic              RST,
  counter_monitor_if.slave mon
);

  // A BOUND that does not fit in WIDTH bits can never be exceeded.
  localparam bit               BoundFits = (64'(BOUND) < (64'(1) << WIDTH));
  localparam logic [WIDTH-1:0] BoundVal  = WIDTH'(BOUND);

  typedef enum logic [1:0] {
    StIdle,
    StLocked,
    StResync
  } state_e;

  state_e           state_q;
  logic             locked_q;
  logic             step_err_q;
  logic             bound_err_q;
  logic [WIDTH-1:0] expected_q;
  logic [ERR_W-1:0] err_count_q;
  logic             first_err_seen_q;
  logic [WIDTH-1:0] first_err_val_q;

  logic sample;
  logic match;
  logic step_hit;
  logic bound_hit;
  logic any_err;

  // Classify the current sample; a clear discards it entirely.
  always_comb begin
    sample    = mon.in_valid && !mon.in_clear;
    match     = (mon.in_data == expected_q);
    step_hit  = sample && (state_q == StLocked) && !match;
    bound_hit = BoundFits && sample && (mon.in_data > BoundVal);
    any_err   = step_hit || bound_hit;
  end

  // Tracking FSM with registered status and error bookkeeping.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q          <= StIdle;
      locked_q         <= 1'b0;
      step_err_q       <= 1'b0;
      bound_err_q      <= 1'b0;
      expected_q       <= '0;
      err_count_q      <= '0;
      first_err_seen_q <= 1'b0;
      first_err_val_q  <= '0;
    end else begin
      step_err_q  <= step_hit;
      bound_err_q <= bound_hit;

      // One count per erroring sample, whatever the number of error types.
      if (any_err) begin
        if (err_count_q != '1) begin
          err_count_q <= err_count_q + ERR_W'(1);
        end
        if (!first_err_seen_q) begin
          first_err_seen_q <= 1'b1;
          first_err_val_q  <= mon.in_data;
        end
      end

      if (mon.in_clear) begin
        state_q    <= StIdle;
        locked_q   <= 1'b0;
        expected_q <= '0;
      end else if (mon.in_valid) begin
        // On a match in_data + 1 equals expected + 1, so every sample re-seeds the reference.
        expected_q <= mon.in_data + WIDTH'(1);
        unique case (state_q)
          StIdle: begin
            state_q  <= StLocked;
            locked_q <= 1'b1;
          end
          StLocked: begin
            if (!match) begin
              state_q  <= StResync;
              locked_q <= 1'b0;
            end
          end
          StResync: begin
            if (match) begin
              state_q  <= StLocked;
              locked_q <= 1'b1;
            end
          end
          default: begin
            state_q  <= StIdle;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mon.locked         = locked_q;
  assign mon.step_err       = step_err_q;
  assign mon.bound_err      = bound_err_q;
  assign mon.expected       = expected_q;
  assign mon.err_count      = err_count_q;
  assign mon.first_err_seen = first_err_seen_q;
  assign mon.first_err_val  = first_err_val_q;

endmodule

// File: tb/tb_counter_monitor.sv
// Self-checking bench: four monitors with different parameters see the same stimulus
// and are compared against a behavioural reference model.
module tb_counter_monitor;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  logic        v_drv;
  logic        c_drv;
  logic [31:0] d_drv;

  counter_monitor_if #(.WIDTH(32), .ERR_W(8)) if0 ();
  counter_monitor_if #(.WIDTH(8),  .ERR_W(8)) if1 ();
  counter_monitor_if #(.WIDTH(4),  .ERR_W(8)) if2 ();
  counter_monitor_if #(.WIDTH(8),  .ERR_W(2)) if3 ();

  assign if0.in_valid = v_drv;
  assign if0.in_clear = c_drv;
  assign if0.in_data  = d_drv;
  assign if1.in_valid = v_drv;
  assign if1.in_clear = c_drv;
  assign if1.in_data  = d_drv[7:0];
  assign if2.in_valid = v_drv;
  assign if2.in_clear = c_drv;
  assign if2.in_data  = d_drv[3:0];
  assign if3.in_valid = v_drv;
  assign if3.in_clear = c_drv;
  assign if3.in_data  = d_drv[7:0];

  counter_monitor #(.WIDTH(32), .BOUND(100), .ERR_W(8)) dut0 (.CLK(CLK), .RST(RST), .mon(if0));
  counter_monitor #(.WIDTH(8),  .BOUND(2),   .ERR_W(8)) dut1 (.CLK(CLK), .RST(RST), .mon(if1));
  counter_monitor #(.WIDTH(4),  .BOUND(15),  .ERR_W(8)) dut2 (.CLK(CLK), .RST(RST), .mon(if2));
  counter_monitor #(.WIDTH(8),  .BOUND(0),   .ERR_W(2)) dut3 (.CLK(CLK), .RST(RST), .mon(if3));

  // Reference model: "has a reference" and "recovering" flags plus modular arithmetic.
  typedef struct {
    int unsigned     w;
    int unsigned     b;
    int unsigned     e;
    bit              has_ref;
    bit              resync;
    bit              step;
    bit              bnd;
    bit              seen;
    longint unsigned exp;
    longint unsigned fval;
    int unsigned     cnt;
  } mdl_t;

  typedef struct {
    logic        locked;
    logic        step;
    logic        bnd;
    logic        seen;
    logic [63:0] exp;
    logic [63:0] fval;
    logic [31:0] cnt;
  } obs_t;

  mdl_t m[4];
  obs_t o[4];
  int   vectors;
  int   miscompares;

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m[i].has_ref = 0;
      m[i].resync  = 0;
      m[i].step    = 0;
      m[i].bnd     = 0;
      m[i].seen    = 0;
      m[i].exp     = 0;
      m[i].fval    = 0;
      m[i].cnt     = 0;
    end
  endfunction

  function automatic void model_step(bit v, longint unsigned d, bit c);
    for (int i = 0; i < 4; i++) begin
      longint unsigned modv = 64'(1) << m[i].w;
      longint unsigned x    = d % modv;
      bit es;
      bit eb;
      m[i].step = 0;
      m[i].bnd  = 0;
      if (c) begin
        m[i].has_ref = 0;
        m[i].resync  = 0;
        m[i].exp     = 0;
      end else if (v) begin
        es = m[i].has_ref && !m[i].resync && (x != m[i].exp);
        eb = x > longint'(m[i].b);
        if (m[i].has_ref) m[i].resync = (x != m[i].exp);
        m[i].has_ref = 1;
        m[i].exp     = (x + 1) % modv;
        m[i].step    = es;
        m[i].bnd     = eb;
        if (es || eb) begin
          if (m[i].cnt < (32'd1 << m[i].e) - 1) m[i].cnt++;
          if (!m[i].seen) begin
            m[i].seen = 1;
            m[i].fval = x;
          end
        end
      end
    end
  endfunction

  function automatic void snap();
    o[0].locked = if0.locked;  o[0].step = if0.step_err;  o[0].bnd = if0.bound_err;
    o[0].seen = if0.first_err_seen;  o[0].exp = 64'(if0.expected);
    o[0].fval = 64'(if0.first_err_val);  o[0].cnt = 32'(if0.err_count);
    o[1].locked = if1.locked;  o[1].step = if1.step_err;  o[1].bnd = if1.bound_err;
    o[1].seen = if1.first_err_seen;  o[1].exp = 64'(if1.expected);
    o[1].fval = 64'(if1.first_err_val);  o[1].cnt = 32'(if1.err_count);
    o[2].locked = if2.locked;  o[2].step = if2.step_err;  o[2].bnd = if2.bound_err;
    o[2].seen = if2.first_err_seen;  o[2].exp = 64'(if2.expected);
    o[2].fval = 64'(if2.first_err_val);  o[2].cnt = 32'(if2.err_count);
    o[3].locked = if3.locked;  o[3].step = if3.step_err;  o[3].bnd = if3.bound_err;
    o[3].seen = if3.first_err_seen;  o[3].exp = 64'(if3.expected);
    o[3].fval = 64'(if3.first_err_val);  o[3].cnt = 32'(if3.err_count);
  endfunction

  // One clock with the given inputs; outputs sampled 1 time unit after the edge.
  task automatic cyc(input bit v, input logic [31:0] d, input bit c);
    v_drv = v;
    d_drv = d;
    c_drv = c;
    @(posedge CLK);
    model_step(v, 64'(d), c);
    #1;
    snap();
  endtask

  task automatic hard_reset();
    v_drv = 0;
    c_drv = 0;
    d_drv = '0;
    RST   = 0;
    model_reset();
    #3;
    RST = 1;
  endtask

  task automatic test_reset();
    v_drv = 0;
    c_drv = 0;
    d_drv = '0;
    RST   = 0;
    model_reset();
    #1;
    snap();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (o[i].locked !== 1'b0 || o[i].step !== 1'b0 || o[i].bnd !== 1'b0
          || o[i].seen !== 1'b0 || o[i].exp !== 64'd0 || o[i].fval !== 64'd0
          || o[i].cnt !== 32'd0) begin
        miscompares++;
        $display("FAIL reset inst%0d: got l=%b s=%b b=%b seen=%b exp=%0d fval=%0d cnt=%0d want all 0",
                 i, o[i].locked, o[i].step, o[i].bnd, o[i].seen, o[i].exp, o[i].fval, o[i].cnt);
      end
    end
    @(posedge CLK);
    #1;
    RST = 1;
  endtask

  task automatic test_lock();
    cyc(1, 5, 0);
    vectors++;
    if (o[0].locked !== 1'b1) begin
      miscompares++;
      $display("FAIL lock_first: got locked=%b want 1", o[0].locked);
    end
    for (int k = 6; k <= 8; k++) begin
      cyc(1, 32'(k), 0);
      vectors++;
      if (o[0].step !== 1'b0 || o[0].bnd !== 1'b0 || o[0].locked !== 1'b1) begin
        miscompares++;
        $display("FAIL lock_seq s=%0d: got step=%b bnd=%b locked=%b want 0 0 1",
                 k, o[0].step, o[0].bnd, o[0].locked);
      end
    end
    vectors++;
    if (o[0].exp !== 64'd9 || o[0].cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL lock_end: got exp=%0d cnt=%0d want 9 0", o[0].exp, o[0].cnt);
    end
  endtask

  task automatic test_step();
    int pulses;
    pulses = 0;
    cyc(0, 0, 1);
    cyc(1, 10, 0);
    cyc(1, 11, 0);
    cyc(1, 13, 0);
    pulses += int'(o[0].step === 1'b1);
    vectors++;
    if (o[0].step !== 1'b1 || o[0].locked !== 1'b0) begin
      miscompares++;
      $display("FAIL step_13: got step=%b locked=%b want 1 0", o[0].step, o[0].locked);
    end
    cyc(1, 14, 0);
    pulses += int'(o[0].step === 1'b1);
    vectors++;
    if (o[0].step !== 1'b0 || o[0].locked !== 1'b1) begin
      miscompares++;
      $display("FAIL step_14: got step=%b locked=%b want 0 1", o[0].step, o[0].locked);
    end
    cyc(1, 15, 0);
    pulses += int'(o[0].step === 1'b1);
    vectors++;
    if (pulses != 1 || o[0].cnt !== 32'd1 || o[0].fval !== 64'd13 || o[0].seen !== 1'b1) begin
      miscompares++;
      $display("FAIL step_end: got pulses=%0d cnt=%0d fval=%0d seen=%b want 1 1 13 1",
               pulses, o[0].cnt, o[0].fval, o[0].seen);
    end
  endtask

  task automatic test_bound();
    hard_reset();
    for (int k = 0; k <= 4; k++) begin
      cyc(1, 32'(k), 0);
      vectors++;
      if (o[1].bnd !== logic'(k > 2) || o[1].step !== 1'b0) begin
        miscompares++;
        $display("FAIL bound s=%0d: got bnd=%b step=%b want %0d 0", k, o[1].bnd, o[1].step, k > 2);
      end
    end
    vectors++;
    if (o[1].cnt !== 32'd2 || o[1].fval !== 64'd3) begin
      miscompares++;
      $display("FAIL bound_end: got cnt=%0d fval=%0d want 2 3", o[1].cnt, o[1].fval);
    end
  endtask

  task automatic test_wrap();
    int vals[4] = '{14, 15, 0, 1};
    hard_reset();
    foreach (vals[k]) begin
      cyc(1, 32'(vals[k]), 0);
      vectors++;
      if (o[2].step !== 1'b0 || o[2].bnd !== 1'b0) begin
        miscompares++;
        $display("FAIL wrap s=%0d: got step=%b bnd=%b want 0 0", vals[k], o[2].step, o[2].bnd);
      end
    end
    vectors++;
    if (o[2].exp !== 64'd2 || o[2].cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL wrap_end: got exp=%0d cnt=%0d want 2 0", o[2].exp, o[2].cnt);
    end
    cyc(1, 3, 1);
    vectors++;
    if (o[2].locked !== 1'b0 || o[2].exp !== 64'd0 || o[2].step !== 1'b0 || o[2].bnd !== 1'b0) begin
      miscompares++;
      $display("FAIL clear: got locked=%b exp=%0d step=%b bnd=%b want 0 0 0 0",
               o[2].locked, o[2].exp, o[2].step, o[2].bnd);
    end
  endtask

  task automatic test_saturate();
    hard_reset();
    for (int k = 1; k <= 10; k++) begin
      cyc(1, 32'(k), 0);
      vectors++;
      if (o[3].bnd !== 1'b1 || o[3].cnt !== 32'((k < 3) ? k : 3)) begin
        miscompares++;
        $display("FAIL saturate s=%0d: got bnd=%b cnt=%0d want 1 %0d",
                 k, o[3].bnd, o[3].cnt, (k < 3) ? k : 3);
      end
    end
  endtask

  task automatic test_back_to_back();
    hard_reset();
    for (int k = 101; k <= 103; k++) begin
      cyc(1, 32'(k), 0);
      vectors++;
      if (o[0].bnd !== 1'b1 || o[0].step !== 1'b0) begin
        miscompares++;
        $display("FAIL b2b s=%0d: got bnd=%b step=%b want 1 0", k, o[0].bnd, o[0].step);
      end
    end
    vectors++;
    if (o[0].cnt !== 32'd3 || o[0].fval !== 64'd101) begin
      miscompares++;
      $display("FAIL b2b_end: got cnt=%0d fval=%0d want 3 101", o[0].cnt, o[0].fval);
    end
  endtask

  task automatic test_async_reset();
    hard_reset();
    cyc(1, 200, 0);
    cyc(1, 201, 0);
    vectors++;
    if (o[0].locked !== 1'b1 || o[0].cnt !== 32'd2) begin
      miscompares++;
      $display("FAIL pre_reset: got locked=%b cnt=%0d want 1 2", o[0].locked, o[0].cnt);
    end
    // No clock edge between asserting reset and sampling.
    RST = 0;
    model_reset();
    #1;
    snap();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (o[i].locked !== 1'b0 || o[i].step !== 1'b0 || o[i].bnd !== 1'b0
          || o[i].seen !== 1'b0 || o[i].exp !== 64'd0 || o[i].fval !== 64'd0
          || o[i].cnt !== 32'd0) begin
        miscompares++;
        $display("FAIL async_reset inst%0d: got l=%b s=%b b=%b seen=%b exp=%0d cnt=%0d want all 0",
                 i, o[i].locked, o[i].step, o[i].bnd, o[i].seen, o[i].exp, o[i].cnt);
      end
    end
    #2;
    RST = 1;
    cyc(1, 50, 0);
    vectors++;
    if (o[0].locked !== 1'b1 || o[0].step !== 1'b0 || o[0].exp !== 64'd51) begin
      miscompares++;
      $display("FAIL post_reset: got locked=%b step=%b exp=%0d want 1 0 51",
               o[0].locked, o[0].step, o[0].exp);
    end
  endtask

  task automatic test_random();
    logic [31:0] d;
    bit          v;
    bit          c;
    int unsigned r;
    hard_reset();
    for (int n = 0; n < 1500; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3, 4, 5: d = 32'(m[0].exp);
        6:                d = $urandom_range(0, 120);
        7:                d = 32'hFFFF_FFFF - $urandom_range(0, 2);
        8:                d = $urandom;
        default:          d = 32'(m[0].exp + 1);
      endcase
      v = ($urandom_range(0, 7) != 0);
      c = ($urandom_range(0, 40) == 0);
      cyc(v, d, c);
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (o[i].locked !== logic'(m[i].has_ref && !m[i].resync) || o[i].step !== m[i].step
            || o[i].bnd !== m[i].bnd || o[i].seen !== m[i].seen || o[i].exp !== m[i].exp
            || o[i].fval !== m[i].fval || o[i].cnt !== m[i].cnt) begin
          miscompares++;
          $display("FAIL random n=%0d inst%0d d=%0h: got l=%b s=%b b=%b seen=%b exp=%0h fval=%0h cnt=%0d want l=%b s=%b b=%b seen=%b exp=%0h fval=%0h cnt=%0d",
                   n, i, d, o[i].locked, o[i].step, o[i].bnd, o[i].seen, o[i].exp, o[i].fval,
                   o[i].cnt, m[i].has_ref && !m[i].resync, m[i].step, m[i].bnd, m[i].seen,
                   m[i].exp, m[i].fval, m[i].cnt);
        end
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m[0].w = 32;  m[0].b = 100;  m[0].e = 8;
    m[1].w = 8;   m[1].b = 2;    m[1].e = 8;
    m[2].w = 4;   m[2].b = 15;   m[2].e = 8;
    m[3].w = 8;   m[3].b = 0;    m[3].e = 2;
    test_reset();
    test_lock();
    test_step();
    test_bound();
    test_wrap();
    test_saturate();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/counter_monitor.md
# counter_monitor

Passive checker that sits at the consuming end of a free-running up-counter output (the 32-bit `out` bus of our counter blocks). It samples the counter value on each valid cycle, checks that every sample is exactly the previous sample plus one (modulo 2^WIDTH) and never exceeds a programmable bound, and reports violations as registered pulses, a saturating error count and a first-error capture. Intended for instantiation beside a counter in simulation and formal harnesses in place of inline immediate assertions.

## Interface

- WIDTH, 32, width of the monitored counter value
- BOUND, 100, largest legal sample value; any sample > BOUND is a bound error
- ERR_W, 8, width of the saturating error counter

- CLK  input  1  clock, all state updates on rising edge
- RST  input  1  asynchronous, active-low reset
- in_valid  input  1  in_data carries a counter sample this cycle
- in_data  input  WIDTH  counter value being monitored
- in_clear  input  1  synchronous restart of tracking (counter was reset upstream)
- locked  output  1  monitor is in LOCKED state
- step_err  output  1  one-cycle pulse: sample did not equal expected
- bound_err  output  1  one-cycle pulse: sample exceeded BOUND
- expected  output  WIDTH  value the next valid sample must carry
- err_count  output  ERR_W  number of cycles with any error, saturating
- first_err_seen  output  1  sticky: at least one error since reset
- first_err_val  output  WIDTH  in_data of the first erroring sample

## Operation

- States: IDLE (no reference), LOCKED (tracking), RESYNC (recovering after a step error).
- IDLE: on in_valid, expected <= in_data + 1, go LOCKED. No step check; bound check applies.
- LOCKED: on in_valid, if in_data == expected: expected <= in_data + 1, stay. Else: step_err pulse, expected <= in_data + 1, go RESYNC.
- RESYNC: on in_valid, if in_data == expected: go LOCKED. Else: expected <= in_data + 1, stay, no step_err (mismatches while resyncing are not counted again).
- in_valid low: state, expected unchanged; no pulses.
- Bound check: in every state, any valid sample with in_data > BOUND pulses bound_err. Independent of step check.
- Both errors in one sample: both pulses assert; err_count increments by 1 (per erroring sample, not per error type).
- err_count saturates at 2^ERR_W - 1; holds there.
- first_err_seen/first_err_val: set on the first erroring sample after reset; frozen thereafter. Cleared only by RST.
- Arithmetic: expected = in_data + 1 truncated to WIDTH; all-ones followed by 0 is a legal step.
- in_clear: highest priority. State <= IDLE, expected <= 0, no pulses that cycle; sample on the same cycle is ignored. err_count and first_err_* retained.

## Timing

- All outputs registered. Sample at edge N produces step_err/bound_err/err_count/first_err_* updates visible after edge N (one-cycle latency); locked and expected reflect the state after edge N.
- step_err, bound_err high for exactly one cycle per offending sample; back-to-back offending samples give back-to-back pulses.
- Reset values (RST low, immediate, async): state IDLE, locked 0, step_err 0, bound_err 0, expected 0, err_count 0, first_err_seen 0, first_err_val 0.
- Reset deassertion mid-stream: first valid sample after release is treated as IDLE capture; no step error on it.
- in_clear and in_valid together: clear wins, sample discarded.

## Test plan

- Reset, then valid samples 5,6,7,8 -> locked 1 after first sample, expected 9 at end, no pulses, err_count 0.
- Samples 10,11,13,14,15 -> step_err one pulse after 13, locked low one cycle after 13, back high after 14; err_count 1, first_err_val 13.
- BOUND=2, samples 0,1,2,3,4 -> bound_err pulses after 3 and 4, no step_err, err_count 2, first_err_val 3.
- WIDTH=4, BOUND=15, samples 14,15,0,1 -> no errors, expected 2; then 3 with in_clear high -> ignored, state IDLE, expected 0.
- ERR_W=2, BOUND=0, ten samples 1..10 -> bound_err every sample, err_count saturates at 3.
- Drive RST low while LOCKED with err_count 2 -> all outputs zero immediately without a clock edge; after release, sample 50 -> locked 1, no step_err.
